canny_hysteresis_threshold: RTL

Final stage of the Canny edge pipeline, directly downstream of `none_LocalMax_value`. It consumes the 16-bit non-maximum-suppressed magnitude stream and classifies each pixel against two runtime thresholds. It applies single-pass 8-neighbour hysteresis over a 3x3 class window built from two on-chip line buffers. It emits a raster-ordered binary edge map with exactly one output per input pixel per frame, and self-flushes the last row at frame end.

---
 rtl/canny_hysteresis_threshold.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/canny_hysteresis_threshold.sv
// canny_hysteresis_threshold
//   Final Canny stage. Classifies each NMS magnitude as strong, weak or none
//   against two runtime thresholds. A 3x3 class window, fed by two WIDTH-deep
//   line buffers, decides each pixel with single-pass, non-transitive 8-neighbour
//   hysteresis. The output is one edge bit per input pixel, in raster order.
//   The last WIDTH+1 pixels of each frame are pushed out by internal flush beats.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   th_low      weak threshold (unsigned), sampled on every accepted beat
//   th_high     strong threshold (unsigned), sampled on every accepted beat
//   in_valid    input beat present
//   in_data     NMS magnitude, raster order
//   in_ready    block accepts input (low while reset is held and during flush)
//   out_valid   one-cycle strobe per output pixel
//   out_edge    1 = edge pixel
//   out_pix     8'hFF for an edge pixel, else 8'h00
//   frame_done  pulses together with the last output of a frame
//
// Build option
//   CANNY_HYST_EN  defined: a weak pixel is an edge when any of its 8 neighbours
//                  is strong. Undefined: only strong pixels are edges. Timing
//                  is identical in both builds.

module canny_hysteresis_threshold #(
    parameter int WIDTH  = 510,
    parameter int HEIGHT = 510,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] th_low,
    input  logic [DATA_W-1:0] th_high,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic              out_edge,
    output logic [7:0]        out_pix,
    output logic              frame_done
);

    // state   | meaning
    // S_FILL  | priming: the first WIDTH+1 accepted beats produce no output
    // S_RUN   | every accepted beat emits the pixel WIDTH+1 positions back
    // S_FLUSH | input blocked; WIDTH+1 class-0 beats drain the last pixels

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int FW = $clog2(WIDTH + 2);

    localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE   = RW'(1);
    // Loaded on entry to flush and counted down to zero: WIDTH+1 beats.
    localparam logic [FW-1:0] FLUSH_LEN = FW'(WIDTH);

    localparam logic [1:0] CLS_NONE   = 2'd0;
    localparam logic [1:0] CLS_WEAK   = 2'd1;
    localparam logic [1:0] CLS_STRONG = 2'd2;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] in_col;
    logic [RW-1:0] in_row;
    logic [CW-1:0] out_col;
    logic [RW-1:0] out_row;
    logic [FW-1:0] flush_cnt;

    // Class history. Index 0 is the oldest row of a window column.
    logic [1:0] lb1 [WIDTH];   // class written WIDTH beats ago
    logic [1:0] lb2 [WIDTH];   // class written 2*WIDTH beats ago
    logic [1:0] win_a [3];     // window column from beat k-2
    logic [1:0] win_b [3];     // window column from beat k-1 (centre column)
    logic [1:0] col_new [3];   // column arriving with the current beat

    logic       in_acc;
    logic       beat;
    logic       emit;
    logic       flush_last;
    logic [1:0] cls;
    logic       border;
    logic       edge_dec;

    assign in_acc     = in_valid && in_ready;
    assign beat       = in_acc || (state == S_FLUSH);
    assign emit       = beat && (state != S_FILL);
    assign flush_last = (state == S_FLUSH) && (flush_cnt == '0);

    always_comb begin
        cls = CLS_NONE;
        if (state != S_FLUSH) begin
            if (in_data >= th_high) begin
                cls = CLS_STRONG;
            end else if (in_data >= th_low) begin
                cls = CLS_WEAK;
            end
        end
    end

    always_comb begin
        col_new[0] = lb2[in_col];
        col_new[1] = lb1[in_col];
        col_new[2] = cls;
    end

    // The centre is the middle tap of the previous beat's column. Its row and
    // column are tracked by the output counters.
    assign border = (out_row == '0) || (out_row == ROW_LAST) ||
                    (out_col == '0) || (out_col == COL_LAST);

`ifdef CANNY_HYST_EN
    logic nb_strong;
    assign nb_strong = (win_a[0] == CLS_STRONG) || (win_a[1] == CLS_STRONG) ||
                       (win_a[2] == CLS_STRONG) || (win_b[0] == CLS_STRONG) ||
                       (win_b[2] == CLS_STRONG) || (col_new[0] == CLS_STRONG) ||
                       (col_new[1] == CLS_STRONG) || (col_new[2] == CLS_STRONG);
    assign edge_dec = !border && ((win_b[1] == CLS_STRONG) ||
                                  ((win_b[1] == CLS_WEAK) && nb_strong));
`else
    assign edge_dec = !border && (win_b[1] == CLS_STRONG);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL: begin
                // The beat at raster index WIDTH is the last silent one.
                if (in_acc && (in_row == ROW_ONE) && (in_col == '0)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (in_acc && (in_row == ROW_LAST) && (in_col == COL_LAST)) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_cnt == '0) begin
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FILL;
            in_ready  <= 1'b0;
            in_col    <= '0;
            in_row    <= '0;
            out_col   <= '0;
            out_row   <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != S_FLUSH);
            if (flush_last) begin
                in_col    <= '0;
                in_row    <= '0;
                out_col   <= '0;
                out_row   <= '0;
                flush_cnt <= '0;
            end else begin
                if (beat) begin
                    if (in_col == COL_LAST) begin
                        in_col <= '0;
                        in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
                    end else begin
                        in_col <= in_col + 1'b1;
                    end
                end
                if (emit) begin
                    if (out_col == COL_LAST) begin
                        out_col <= '0;
                        out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
                    end else begin
                        out_col <= out_col + 1'b1;
                    end
                end
                if (state == S_FLUSH) begin
                    flush_cnt <= flush_cnt - 1'b1;
                end else if (state_nxt == S_FLUSH) begin
                    flush_cnt <= FLUSH_LEN;
                end
            end
        end
    end

    // Line buffers and window need no reset: stale taps only ever reach border
    // centres, which are forced to 0.
    always_ff @(posedge clk) begin
        if (beat) begin
            lb1[in_col] <= cls;
            lb2[in_col] <= lb1[in_col];
            win_a       <= win_b;
            win_b       <= col_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_edge   <= 1'b0;
            out_pix    <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= emit;
            out_edge   <= emit && edge_dec;
            out_pix    <= {8{emit && edge_dec}};
            frame_done <= emit && flush_last;
        end
    end

endmodule
